// File: rtl/button_debouncer_if.sv
// button_debouncer_if: raw pins in, debounced levels and sample strobe out
//   btn_in : raw asynchronous button pins (driven by master)
//   btn_db : debounced active-high levels (driven by slave)
//   tick   : shared sample strobe (driven by slave)
interface button_debouncer_if #(parameter int NUM_BTN = 4);
  logic [NUM_BTN-1:0] btn_in;
  logic [NUM_BTN-1:0] btn_db;
  logic               tick;
  modport master (output btn_in, input btn_db, tick);
  modport slave  (input btn_in, output btn_db, tick);
endinterface

// File: rtl/button_debouncer.sv
// button_debouncer: synchronises and tick-filters NUM_BTN bouncy buttons into clean active-high levels
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : slave side of button_debouncer_if (btn_in in; btn_db, tick out)
module button_debouncer #(
  parameter int NUM_BTN      = 4,
  parameter int CLK_DIV      = 100000,
  parameter int STABLE_TICKS = 10,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input logic clk,
  input logic rst,
  button_debouncer_if.slave bus
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [1:0] ST_LO   = 2'd0;
  localparam logic [1:0] WAIT_HI = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] WAIT_LO = 2'd3;
  localparam logic [NUM_BTN-1:0] IDLE = {NUM_BTN{ACTIVE_LOW}};
  logic [DW-1:0]      div_q, div_d;
  logic               tick_q, wrap;
  logic [NUM_BTN-1:0] sync1_q, sync2_q, s, db;
  always_comb begin
    wrap  = div_q == DW'(CLK_DIV - 1);
    div_d = wrap ? '0 : div_q + 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      tick_q  <= 1'b0;
      sync1_q <= IDLE;
      sync2_q <= IDLE;
    end else begin
      div_q   <= div_d;
      tick_q  <= wrap;
      sync1_q <= bus.btn_in;
      sync2_q <= sync1_q;
    end
  end
  assign s = sync2_q ^ IDLE;
  // State bit 1 is the debounced level, so btn_db comes straight from a register.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    logic [1:0]    st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d, nxt;
    logic          lvl, differ, done;
    always_comb begin
      lvl    = st_q[1];
      differ = s[i] ^ lvl;
      nxt    = cnt_q + 1'b1;
      done   = nxt == CW'(STABLE_TICKS);
      st_d   = !tick_q ? st_q :
               !differ ? (lvl ? ST_HI : ST_LO) :
               done    ? (lvl ? ST_LO : ST_HI) :
                         (lvl ? WAIT_LO : WAIT_HI);
      cnt_d  = !tick_q ? cnt_q : (differ && !done) ? nxt : '0;
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q  <= ST_LO;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
      end
    end
    assign db[i] = st_q[1];
  end
  assign bus.btn_db = db;
  assign bus.tick   = tick_q;
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: randomized self-checking bench against a sample-run-length reference model
module tb_button_debouncer;
  localparam int NB = 4;
  localparam int CD = 4;
  localparam int ST = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  button_debouncer_if #(.NUM_BTN(NB)) bus_h ();
  button_debouncer_if #(.NUM_BTN(NB)) bus_l ();
  button_debouncer #(.NUM_BTN(NB), .CLK_DIV(CD), .STABLE_TICKS(ST), .ACTIVE_LOW(1'b0))
    dut_h (.clk(clk), .rst(rst), .bus(bus_h.slave));
  button_debouncer #(.NUM_BTN(NB), .CLK_DIV(CD), .STABLE_TICKS(ST), .ACTIVE_LOW(1'b1))
    dut_l (.clk(clk), .rst(rst), .bus(bus_l.slave));

  // Reference model: each channel counts consecutive tick samples that differ
  // from its accepted level; ST of them in a row flips the level.
  logic [NB-1:0] m_db [2];
  logic [NB-1:0] m_s  [2];
  logic [NB-1:0] m_p  [2];
  int            run  [2][NB];
  int            n_edge;
  logic          m_tick;

  task automatic model_reset();
    n_edge = 0;
    m_tick = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_db[k] = '0;
      m_s[k]  = '0;
      m_p[k]  = '0;
      for (int c = 0; c < NB; c++) run[k][c] = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      for (int k = 0; k < 2; k++) begin
        if (m_tick) begin
          for (int c = 0; c < NB; c++) begin
            if (m_s[k][c] != m_db[k][c]) begin
              run[k][c]++;
              if (run[k][c] == ST) begin
                m_db[k][c] = ~m_db[k][c];
                run[k][c] = 0;
              end
            end else run[k][c] = 0;
          end
        end
        m_s[k] = m_p[k];
      end
      m_p[0] = bus_h.btn_in;
      m_p[1] = ~bus_l.btn_in;
      n_edge++;
      m_tick = (n_edge % CD) == 0;
    end
    #1;
  endtask

  task automatic test_reset();
    bus_h.btn_in = '0;
    bus_l.btn_in = '1;
    rst = 1'b1;
    model_reset();
    repeat (3) step();
    n_chk++;
    if ({bus_l.btn_db, bus_h.btn_db, bus_h.tick} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: got db_l=%b db_h=%b tick=%b, need all 0", bus_l.btn_db, bus_h.btn_db, bus_h.tick);
    end
    rst = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      step();
      n_chk += 2;
      if ({bus_l.btn_db, bus_h.btn_db} !== '0) begin
        n_fail++;
        $display("FAIL reset_db cyc %0d: got %b_%b, need 0", c, bus_l.btn_db, bus_h.btn_db);
      end
      if (bus_h.tick !== ((c % CD) == 0)) begin
        n_fail++;
        $display("FAIL reset_tick cyc %0d: got %b, need %b", c, bus_h.tick, (c % CD) == 0);
      end
    end
  endtask

  task automatic test_press();
    int rise = -1;
    repeat ($urandom_range(0, 3)) step();
    bus_h.btn_in[0] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      n_chk += 2;
      if ({bus_l.btn_db, bus_h.btn_db} !== {m_db[1], m_db[0]}) begin
        n_fail++;
        $display("FAIL press_db cyc %0d: got %b_%b, need %b_%b", c, bus_l.btn_db, bus_h.btn_db, m_db[1], m_db[0]);
      end
      if (bus_h.tick !== m_tick) begin
        n_fail++;
        $display("FAIL press_tick cyc %0d: got %b, need %b", c, bus_h.tick, m_tick);
      end
      if (rise < 0 && bus_h.btn_db[0] === 1'b1) rise = c;
    end
    n_chk += 2;
    if (rise < 1 || rise > 15) begin
      n_fail++;
      $display("FAIL press_latency: rise at cycle %0d, need 1..15", rise);
    end
    if (bus_h.btn_db !== 4'b0001) begin
      n_fail++;
      $display("FAIL press_level: got %b, need 0001", bus_h.btn_db);
    end
    bus_h.btn_in[0] = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      n_chk++;
      if ({bus_l.btn_db, bus_h.btn_db} !== {m_db[1], m_db[0]}) begin
        n_fail++;
        $display("FAIL release_db cyc %0d: got %b_%b, need %b_%b", c, bus_l.btn_db, bus_h.btn_db, m_db[1], m_db[0]);
      end
    end
    n_chk++;
    if (bus_h.btn_db !== 4'b0000) begin
      n_fail++;
      $display("FAIL release_level: got %b, need 0000", bus_h.btn_db);
    end
  endtask

  task automatic test_bounce();
    logic [2:0] pat = 3'b101;
    repeat ($urandom_range(0, 3)) step();
    for (int b = 2; b >= 0; b--) begin
      bus_h.btn_in[1] = pat[b];
      for (int c = 0; c < CD; c++) begin
        step();
        n_chk += 2;
        if (bus_h.btn_db[1] !== 1'b0) begin
          n_fail++;
          $display("FAIL bounce_quiet: got %b, need 0", bus_h.btn_db[1]);
        end
        if (bus_h.btn_db !== m_db[0]) begin
          n_fail++;
          $display("FAIL bounce_db: got %b, need %b", bus_h.btn_db, m_db[0]);
        end
      end
    end
    for (int c = 1; c <= 20; c++) begin
      step();
      n_chk++;
      if (bus_h.btn_db !== m_db[0]) begin
        n_fail++;
        $display("FAIL bounce_hold cyc %0d: got %b, need %b", c, bus_h.btn_db, m_db[0]);
      end
    end
    n_chk++;
    if (bus_h.btn_db[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL bounce_accept: got %b, need 1", bus_h.btn_db[1]);
    end
    bus_h.btn_in[1] = 1'b0;
    repeat (20) step();
  endtask

  task automatic test_glitch();
    int guard = 0;
    while (!m_tick && guard < 2 * CD) begin
      step();
      guard++;
    end
    n_chk++;
    if (!m_tick) begin
      n_fail++;
      $display("FAIL glitch_align: no tick within %0d cycles", 2 * CD);
    end
    bus_h.btn_in[2] = 1'b1;
    step();
    step();
    bus_h.btn_in[2] = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      n_chk += 2;
      if (bus_h.btn_db[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch_db cyc %0d: got %b, need 0", c, bus_h.btn_db[2]);
      end
      if (bus_h.btn_db !== m_db[0]) begin
        n_fail++;
        $display("FAIL glitch_model cyc %0d: got %b, need %b", c, bus_h.btn_db, m_db[0]);
      end
    end
  endtask

  task automatic test_simul();
    int first = -1;
    repeat ($urandom_range(0, 3)) step();
    bus_h.btn_in = 4'b1111;
    for (int c = 1; c <= 20; c++) begin
      step();
      n_chk += 2;
      if (bus_h.btn_db !== 4'b0000 && bus_h.btn_db !== 4'b1111) begin
        n_fail++;
        $display("FAIL simul_together cyc %0d: got %b, need 0000 or 1111", c, bus_h.btn_db);
      end
      if (bus_h.btn_db !== m_db[0]) begin
        n_fail++;
        $display("FAIL simul_db cyc %0d: got %b, need %b", c, bus_h.btn_db, m_db[0]);
      end
      if (first < 0 && bus_h.btn_db === 4'b1111) first = c;
    end
    n_chk++;
    if (first < 0) begin
      n_fail++;
      $display("FAIL simul_rise: got %b, need 1111", bus_h.btn_db);
    end
    rst = 1'b1;
    model_reset();
    #2;
    n_chk++;
    if (bus_h.btn_db !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_rst: got %b, need 0000", bus_h.btn_db);
    end
    repeat (2) step();
    rst = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      step();
      n_chk += 2;
      if (bus_h.btn_db !== (c >= 13 ? 4'b1111 : 4'b0000)) begin
        n_fail++;
        $display("FAIL requalify cyc %0d: got %b, need %b", c, bus_h.btn_db, c >= 13 ? 4'b1111 : 4'b0000);
      end
      if (bus_h.btn_db !== m_db[0]) begin
        n_fail++;
        $display("FAIL requalify_model cyc %0d: got %b, need %b", c, bus_h.btn_db, m_db[0]);
      end
    end
    bus_h.btn_in = 4'b0000;
    repeat (3 * CD) step();
    bus_h.btn_in = 4'b0101;
    repeat (5) step();
    rst = 1'b1;
    model_reset();
    #2;
    n_chk++;
    if (bus_h.btn_db !== 4'b0000) begin
      n_fail++;
      $display("FAIL wait_rst: got %b, need 0000", bus_h.btn_db);
    end
    step();
    rst = 1'b0;
    bus_h.btn_in = 4'b0000;
    repeat (4) step();
  endtask

  task automatic test_active_low();
    n_chk++;
    if (bus_l.btn_db !== 4'b0000) begin
      n_fail++;
      $display("FAIL al_idle: got %b, need 0000", bus_l.btn_db);
    end
    bus_l.btn_in[0] = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      n_chk++;
      if (bus_l.btn_db !== m_db[1]) begin
        n_fail++;
        $display("FAIL al_db cyc %0d: got %b, need %b", c, bus_l.btn_db, m_db[1]);
      end
    end
    n_chk++;
    if (bus_l.btn_db !== 4'b0001) begin
      n_fail++;
      $display("FAIL al_press: got %b, need 0001", bus_l.btn_db);
    end
  endtask

  task automatic test_random();
    for (int c = 1; c <= 600; c++) begin
      if ($urandom_range(0, 5) == 0) bus_h.btn_in[$urandom_range(0, NB - 1)] ^= 1'b1;
      if ($urandom_range(0, 5) == 0) bus_l.btn_in[$urandom_range(0, NB - 1)] ^= 1'b1;
      step();
      n_chk += 2;
      if ({bus_l.btn_db, bus_h.btn_db} !== {m_db[1], m_db[0]}) begin
        n_fail++;
        $display("FAIL random_db cyc %0d: got %b_%b, need %b_%b", c, bus_l.btn_db, bus_h.btn_db, m_db[1], m_db[0]);
      end
      if ({bus_l.tick, bus_h.tick} !== {m_tick, m_tick}) begin
        n_fail++;
        $display("FAIL random_tick cyc %0d: got %b%b, need %b", c, bus_l.tick, bus_h.tick, m_tick);
      end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_glitch();
    test_simul();
    test_active_low();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
